fir_interp_4x_mac: RTL

- Polyphase 4x interpolating FIR engine that sits directly upstream of the 64-entry tap ROM.
- Drives the ROM address and valid, and consumes the ROM's registered coefficient output.
- For each accepted input sample x[n] it emits four outputs y[4n+p], p=0..3, where y[4n+p] = sum over k=0..15 of h[4k+p]·x[n-k].
- Uses one time-multiplexed multiplier. Sits between the input sample stream and the DSP output stream.

---
 rtl/fir_interp_4x_mac.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fir_interp_4x_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fir_interp_4x_mac
//  Purpose  : Polyphase 4x interpolating FIR; one multiplier, 64-tap ROM fed
//             by address/valid, four rounded and saturated outputs per input.
//  Revision : 1.0  initial release
// ============================================================================
module fir_interp_4x_mac #(
    parameter int OUT_SHIFT = 13,
    parameter int ACC_W     = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [5:0]  coef_address,
    output logic        coef_valid,
    input  logic [15:0] coef_data,
    input  logic        coef_data_valid,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] c_ROUND = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] c_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] c_MIN   = ACC_W'(-32768);

    state_t                   r_state;
    logic signed [15:0]       r_hist [16];
    logic [3:0]               r_k;
    logic [3:0]               r_k_d;
    logic [1:0]               r_p;
    logic                     r_drain;
    logic signed [31:0]       r_prod;
    logic                     r_prod_valid;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_rounded;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [15:0]              w_sat;

    // The final accumulate and the output rounding share one edge so the
    // result is registered exactly two cycles after the last address.
    assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};
    assign w_acc_next = r_prod_valid ? (r_acc + w_prod_ext) : r_acc;
    assign w_rounded  = w_acc_next + c_ROUND;
    assign w_shifted  = w_rounded >>> OUT_SHIFT;
    assign w_sat      = (w_shifted > c_MAX) ? 16'h7FFF :
                        (w_shifted < c_MIN) ? 16'h8000 : w_shifted[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            for (int i = 0; i < 16; i++) r_hist[i] <= '0;
            r_k          <= '0;
            r_k_d        <= '0;
            r_p          <= '0;
            r_drain      <= 1'b0;
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
            din_ready    <= 1'b0;
            coef_address <= '0;
            coef_valid   <= 1'b0;
            dout         <= '0;
            dout_valid   <= 1'b0;
        end else begin
            r_prod_valid <= coef_data_valid;
            if (coef_data_valid)
                r_prod <= $signed(coef_data) * r_hist[r_k_d];
            r_k_d <= r_k;
            r_acc <= w_acc_next;

            case (r_state)
                ST_IDLE: begin
                    din_ready <= 1'b1;
                    if (din_ready && din_valid) begin
                        for (int i = 15; i > 0; i--) r_hist[i] <= r_hist[i-1];
                        r_hist[0]    <= $signed(din);
                        r_p          <= 2'd0;
                        r_k          <= 4'd0;
                        r_acc        <= '0;
                        coef_address <= 6'd0;
                        coef_valid   <= 1'b1;
                        din_ready    <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_k == 4'd15) begin
                        coef_valid <= 1'b0;
                        r_drain    <= 1'b0;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_k          <= r_k + 4'd1;
                        coef_address <= {r_k + 4'd1, r_p};
                    end
                end
                ST_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        dout       <= w_sat;
                        dout_valid <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (r_p == 2'd3) begin
                            din_ready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_p          <= r_p + 2'd1;
                            r_k          <= 4'd0;
                            r_acc        <= '0;
                            coef_address <= {4'd0, r_p + 2'd1};
                            coef_valid   <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
